lsu: RTL and testbench

Load/store unit between the RV32 core's execute stage and the `ram` data memory. Accepts one load or store per handshake and translates it into `ram`'s one-hot `write_enable` / byte-lane protocol. Returns load data sign- or zero-extended to 32 bits. Optionally splits misaligned accesses into multiple memory beats.

---
 rtl/lsu_pkg.sv | 58 +++++
 rtl/lsu_extend.sv | 24 ++
 rtl/lsu.sv | 199 +++++++++++++++++++
 tb/tb_lsu.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: data width, size codes,
// ram write-enable one-hots, FSM state encoding and small decode helpers.
// Optional feature macro: LSU_MISALIGNED_EN adds the split-access states.
package lsu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] LSU_SIZE_B = 2'd0;
    localparam logic [1:0] LSU_SIZE_H = 2'd1;
    localparam logic [1:0] LSU_SIZE_W = 2'd2;

    localparam logic [2:0] WE_NONE = 3'b000;
    localparam logic [2:0] WE_WORD = 3'b001;
    localparam logic [2:0] WE_HALF = 3'b010;
    localparam logic [2:0] WE_BYTE = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DONE   = 3'd3
`ifdef LSU_MISALIGNED_EN
        ,
        ST_ISSUE2 = 3'd4,
        ST_WAIT2  = 3'd5,
        ST_STB    = 3'd6
`endif
    } lsu_state_e;

    // Control fields of an accepted request
    typedef struct packed {
        logic       we;
        logic [1:0] size;
        logic       is_unsigned;
    } lsu_ctrl_t;

    // Size code 3 behaves as a word
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'd3) ? LSU_SIZE_W : size;
    endfunction

    function automatic logic [2:0] size_we(input logic [1:0] size);
        case (size)
            LSU_SIZE_W: return WE_WORD;
            LSU_SIZE_H: return WE_HALF;
            default:    return WE_BYTE;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            LSU_SIZE_H: return off[0];
            LSU_SIZE_W: return off != 2'd0;
            default:    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Size truncation and sign/zero extension of an assembled load word.
// Ports: data (raw word, LSB-aligned), size (normalised size code),
//        is_unsigned (zero-extend), result_c (extended result, combinational).
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] data,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] result_c
);

    always_comb begin
        result_c = data;
        case (size)
            LSU_SIZE_B: result_c = is_unsigned ? {24'd0, data[7:0]}
                                               : {{24{data[7]}}, data[7:0]};
            LSU_SIZE_H: result_c = is_unsigned ? {16'd0, data[15:0]}
                                               : {{16{data[15]}}, data[15:0]};
            default:    result_c = data;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request per handshake, translated into ram's one-hot
// write_enable protocol; load data returned extended to 32 bits.
// Ports: clk, reset (async, active-high); req_* core request + req_ready;
//        resp_* one-cycle response; mem_* ram address/enable/data/readback.
// Macro LSU_MISALIGNED_EN: split misaligned accesses into several beats;
// without it misaligned requests fault with no memory activity.
module lsu
    import lsu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_fault,
    output logic [XLEN-1:0] mem_addr,
    output logic [2:0]      mem_write_enable,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    lsu_state_e state, state_next;
    lsu_ctrl_t  ctrl_in_c, ctrl_q;
    logic       accept_c, mis_in_c, req_mis_q, fault_in_c, fault_c;
    logic [XLEN-1:0] load_word_c, load_ext_c;

    logic            req_ready_d, resp_valid_d, resp_fault_d;
    logic [XLEN-1:0] resp_rdata_d, mem_addr_d, mem_wdata_d;
    logic [2:0]      mem_we_d;

`ifdef LSU_MISALIGNED_EN
    logic [1:0]      off_q, beat_q, beat_next_c, last_beat_c;
    logic [XLEN-1:0] beat0_q;
    logic            two_beat_c;
    logic [2:0]      lo_bytes_c;
`endif

    // Request decode
    always_comb begin
        accept_c              = req_valid & req_ready;
        ctrl_in_c.we          = req_we;
        ctrl_in_c.size        = norm_size(req_size);
        ctrl_in_c.is_unsigned = req_unsigned;
        mis_in_c              = is_misaligned(ctrl_in_c.size, req_addr[1:0]);
`ifdef LSU_MISALIGNED_EN
        fault_in_c = 1'b0;
        fault_c    = 1'b0;
`else
        fault_in_c = mis_in_c;
        fault_c    = req_mis_q;
`endif
    end

`ifdef LSU_MISALIGNED_EN
    // Split-access bookkeeping: beat counter limits and two-beat load merge
    always_comb begin
        beat_next_c = beat_q + 2'd1;
        last_beat_c = (ctrl_q.size == LSU_SIZE_W) ? 2'd3 : 2'd1;
        two_beat_c  = req_mis_q && ((ctrl_q.size == LSU_SIZE_W) || (off_q == 2'd3));
        lo_bytes_c  = 3'd4 - {1'b0, off_q};
        if (state == ST_WAIT2)
            load_word_c = (beat0_q & (32'hFFFF_FFFF >> {off_q, 3'b000}))
                        | (mem_rdata << {lo_bytes_c, 3'b000});
        else
            load_word_c = mem_rdata;
    end
`else
    always_comb load_word_c = mem_rdata;
`endif

    lsu_extend u_extend (
        .data        (load_word_c),
        .size        (ctrl_q.size),
        .is_unsigned (ctrl_q.is_unsigned),
        .result_c    (load_ext_c)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: state_next = accept_c ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: begin
                state_next = ctrl_q.we ? ST_DONE : ST_WAIT;
`ifdef LSU_MISALIGNED_EN
                if (ctrl_q.we && req_mis_q) state_next = ST_STB;
`else
                if (req_mis_q) state_next = ST_DONE;
`endif
            end
`ifdef LSU_MISALIGNED_EN
            ST_WAIT:   state_next = two_beat_c ? ST_ISSUE2 : ST_DONE;
            ST_ISSUE2: state_next = ST_WAIT2;
            ST_WAIT2:  state_next = ST_DONE;
            ST_STB:    state_next = (beat_q == last_beat_c) ? ST_DONE : ST_STB;
`else
            ST_WAIT:   state_next = ST_DONE;
`endif
            default:   state_next = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs, keyed on the state being entered
    always_comb begin
        req_ready_d  = 1'b0;
        resp_valid_d = 1'b0;
        resp_fault_d = 1'b0;
        resp_rdata_d = '0;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        mem_we_d     = WE_NONE;
        case (state_next)
            ST_IDLE: req_ready_d = 1'b1;
            // Only reached through acceptance, so the first beat comes from the accepted request
            ST_ISSUE: begin
                if (!fault_in_c) begin
                    mem_addr_d  = req_addr;
                    mem_wdata_d = req_wdata;
                    if (req_we) mem_we_d = mis_in_c ? WE_BYTE : size_we(ctrl_in_c.size);
                end
            end
`ifdef LSU_MISALIGNED_EN
            ST_ISSUE2: mem_addr_d = {mem_addr[XLEN-1:2], 2'b00} + 32'd4;
            // Byte split: walk up one address and one data byte per beat
            ST_STB: begin
                mem_addr_d  = mem_addr + 32'd1;
                mem_wdata_d = mem_wdata >> 8;
                mem_we_d    = WE_BYTE;
            end
`endif
            ST_DONE: begin
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b1;
                resp_fault_d = fault_c;
                if (!ctrl_q.we && !fault_c) resp_rdata_d = load_ext_c;
            end
            default: ;
        endcase
    end

    // Output and request registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_ready        <= 1'b0;
            resp_valid       <= 1'b0;
            resp_fault       <= 1'b0;
            resp_rdata       <= '0;
            mem_addr         <= '0;
            mem_wdata        <= '0;
            mem_write_enable <= WE_NONE;
            ctrl_q           <= '0;
            req_mis_q        <= 1'b0;
        end else begin
            req_ready        <= req_ready_d;
            resp_valid       <= resp_valid_d;
            resp_fault       <= resp_fault_d;
            resp_rdata       <= resp_rdata_d;
            mem_addr         <= mem_addr_d;
            mem_wdata        <= mem_wdata_d;
            mem_write_enable <= mem_we_d;
            if (accept_c) begin
                ctrl_q    <= ctrl_in_c;
                req_mis_q <= mis_in_c;
            end
        end
    end

`ifdef LSU_MISALIGNED_EN
    // Split-access registers: offset, store beat index, first load beat
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            off_q   <= 2'd0;
            beat_q  <= 2'd0;
            beat0_q <= '0;
        end else begin
            if (accept_c) begin
                off_q  <= req_addr[1:0];
                beat_q <= 2'd0;
            end else if (state_next == ST_STB) begin
                beat_q <= beat_next_c;
            end
            if (state == ST_WAIT) beat0_q <= mem_rdata;
        end
    end
`endif

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: byte-array ram model on the memory side and
// a transaction-level reference model (byte memory + timing rules).
// Honours LSU_MISALIGNED_EN to pick split or fault behaviour.
module tb_lsu;

`ifdef LSU_MISALIGNED_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_fault;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_write_enable;

    always #5 clk = ~clk;

    lsu dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_we           (req_we),
        .req_size         (req_size),
        .req_unsigned     (req_unsigned),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_fault       (resp_fault),
        .mem_addr         (mem_addr),
        .mem_write_enable (mem_write_enable),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // ---------------- ram model (256 bytes, aliased on addr[7:0]) ----------------
    typedef struct packed {
        logic [2:0]  we;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic [7:0]  ram [256];
    wr_t         wlog[$];
    logic        bad_we = 1'b0;
    logic [7:0]  rd_base;
    logic [31:0] rd_word, wr_data_m;

    assign rd_base   = {mem_addr[7:2], 2'b00};
    assign rd_word   = {ram[rd_base + 8'd3], ram[rd_base + 8'd2], ram[rd_base + 8'd1], ram[rd_base]};
    assign wr_data_m = (mem_write_enable == 3'b001) ? mem_wdata :
                       (mem_write_enable == 3'b010) ? {16'd0, mem_wdata[15:0]} :
                                                      {24'd0, mem_wdata[7:0]};

    always @(posedge clk) begin
        mem_rdata <= rd_word >> (8 * mem_addr[1:0]);
        if ($countones(mem_write_enable) > 1) bad_we <= 1'b1;
        case (mem_write_enable)
            3'b001: for (int i = 0; i < 4; i++) ram[mem_addr[7:0] + 8'(i)] <= mem_wdata[8*i +: 8];
            3'b010: for (int i = 0; i < 2; i++) ram[mem_addr[7:0] + 8'(i)] <= mem_wdata[8*i +: 8];
            3'b100: ram[mem_addr[7:0]] <= mem_wdata[7:0];
            default: ;
        endcase
        if (mem_write_enable != 3'b000)
            wlog.push_back(wr_t'{we: mem_write_enable, addr: mem_addr, data: wr_data_m});
    end

    // ---------------- reference model ----------------
    logic [7:0]  refm [256];
    logic [31:0] last_rd;

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    task automatic xact(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
        int          n, exp_lat, lat, guard;
        bit          mis, flt;
        logic [31:0] exp_rd, raw, prev_addr;
        logic [2:0]  exp_we0;
        wr_t         exp_w[$];

        n   = nbytes(size);
        mis = (addr % 32'(n)) != 0;
        flt = mis && !MIS_EN;

        exp_rd = 32'd0;
        if (!we && !flt) begin
            raw = 32'd0;
            for (int i = 0; i < n; i++) raw |= 32'(refm[addr[7:0] + 8'(i)]) << (8 * i);
            if (!uns && n < 4 && raw[8*n-1]) raw |= 32'hFFFF_FFFF << (8 * n);
            exp_rd = raw;
        end

        if (we && !flt) begin
            if (mis) begin
                for (int k = 0; k < n; k++)
                    exp_w.push_back(wr_t'{we: 3'b100, addr: addr + 32'(k), data: 32'(wdata[8*k +: 8])});
            end else begin
                raw = (n == 4) ? wdata : (n == 2) ? {16'd0, wdata[15:0]} : {24'd0, wdata[7:0]};
                exp_w.push_back(wr_t'{we: (n == 4) ? 3'b001 : (n == 2) ? 3'b010 : 3'b100,
                                      addr: addr, data: raw});
            end
            for (int i = 0; i < n; i++) refm[addr[7:0] + 8'(i)] = wdata[8*i +: 8];
        end

        // Latency from acceptance edge to resp_valid
        if (flt || (we && !mis))              exp_lat = 1;
        else if (we)                          exp_lat = n;
        else if (32'(addr[1:0]) + 32'(n) > 4) exp_lat = 4;
        else                                  exp_lat = 2;
        exp_we0 = (exp_w.size() > 0) ? exp_w[0].we : 3'b000;

        guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("ready_wait", 32'(req_ready), 32'd1);
        prev_addr = mem_addr;
        wlog.delete();
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("ready_fall", 32'(req_ready), 32'd0);
        check("resp_pulse", 32'(resp_valid), 32'd0);
        check("issue_addr", mem_addr, flt ? prev_addr : addr);
        check("issue_we", 32'(mem_write_enable), 32'(exp_we0));

        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (resp_valid) begin
                lat = k;
                break;
            end
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("rdata", resp_rdata, exp_rd);
        check("fault", 32'(resp_fault), 32'(flt));
        check("ready_rise", 32'(req_ready), 32'd1);
        check("n_writes", 32'(wlog.size()), 32'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < wlog.size(); i++) begin
            check("wr_we", 32'(wlog[i].we), 32'(exp_w[i].we));
            check("wr_addr", wlog[i].addr, exp_w[i].addr);
            check("wr_data", wlog[i].data, exp_w[i].data);
        end
        last_rd = resp_rdata;
    endtask

    // Reset during a load in flight: WAIT2 when splitting is built in, WAIT otherwise
    task automatic reset_mid;
        int guard;
        bit seen;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr  = MIS_EN ? 32'h41 : 32'h40;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (MIS_EN ? 2 : 0) @(posedge clk);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_fault", 32'(resp_fault), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_we", 32'(mem_write_enable), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (resp_valid) seen = 1'b1;
        end
        check("rst_no_resp", 32'(seen), 32'd0);
        check("rst_ready_back", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] a;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 32'(req_ready), 32'd0);
        check("reset_resp_valid", 32'(resp_valid), 32'd0);
        check("reset_mem_we", 32'(mem_write_enable), 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        reset = 1'b0;

        // Fill memory through aligned word stores
        for (int w = 0; w < 64; w++) xact(1'b1, 2'd2, 1'b0, 32'(4 * w), $urandom);

        // Directed cases
        xact(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        xact(1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
        check("plan_lw", last_rd, 32'hDEADBEEF);
        xact(1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF0000);
        xact(1'b0, 2'd0, 1'b0, 32'h13, 32'd0);
        check("plan_lb", last_rd, 32'hFFFFFF80);
        xact(1'b0, 2'd0, 1'b1, 32'h13, 32'd0);
        check("plan_lbu", last_rd, 32'h00000080);
        xact(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000BEEF);
        xact(1'b0, 2'd1, 1'b0, 32'h12, 32'd0);
        check("plan_lh", last_rd, 32'hFFFFBEEF);
        xact(1'b1, 2'd2, 1'b0, 32'h20, 32'h44332211);
        xact(1'b1, 2'd2, 1'b0, 32'h24, 32'h88776655);
        xact(1'b0, 2'd2, 1'b0, 32'h21, 32'd0);
        check("plan_mis_lw", last_rd, MIS_EN ? 32'h55443322 : 32'd0);
        xact(1'b0, 2'd1, 1'b1, 32'h23, 32'd0);
        xact(1'b0, 2'd1, 1'b0, 32'h21, 32'd0);
        xact(1'b1, 2'd2, 1'b0, 32'h31, 32'hA1B2C3D4);
        xact(1'b0, 2'd2, 1'b0, 32'h30, 32'd0);
        xact(1'b0, 2'd3, 1'b0, 32'h2000_0024, 32'd0);

        reset_mid();

        // Randomised traffic
        for (int t = 0; t < 120; t++) begin
            a = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) a |= 32'h2000_0000;
            xact(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 a, $urandom);
        end

        check("we_onehot", 32'(bad_we), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
